// File: rtl/imem_load_ctrl_if.sv
// AXI4-Lite slave bus used to load instruction memory and control the core.
// The design side uses the slave modport; a bus driver uses master.
interface imem_load_ctrl_if;
   logic        s_awvalid;
   logic        s_awready;
   logic [11:0] s_awaddr;
   logic        s_wvalid;
   logic        s_wready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_bvalid;
   logic        s_bready;
   logic [1:0]  s_bresp;
   logic        s_arvalid;
   logic        s_arready;
   logic [11:0] s_araddr;
   logic        s_rvalid;
   logic        s_rready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;

   modport slave (
      input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
      input  s_arvalid, s_araddr, s_rready,
      output s_awready, s_wready, s_bvalid, s_bresp,
      output s_arready, s_rvalid, s_rdata, s_rresp
   );

   modport master (
      output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
      output s_arvalid, s_araddr, s_rready,
      input  s_awready, s_wready, s_bvalid, s_bresp,
      input  s_arready, s_rvalid, s_rdata, s_rresp
   );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction memory loader: AXI4-Lite writes fill imem while the core is held,
// a CTRL register releases the core and a STATUS register reports the load count.
module imem_load_ctrl #(
   parameter int ROW_I = 256
) (
   input  logic             clk,
   input  logic             reset_n,
   imem_load_ctrl_if.slave  bus,
   output logic             instruction_write,
   output logic [31:0]      instruction_data,
   output logic [7:0]       instruction_addr,
   output logic             core_run
);

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [11:0] ADDR_CTRL   = 12'h800;
   localparam logic [11:0] ADDR_STATUS = 12'h804;
   localparam logic [8:0]  COUNT_MAX   = 9'(ROW_I);

   w_state_t    w_state;
   r_state_t    r_state;
   logic        aw_done;
   logic        w_done;
   logic [11:0] aw_addr;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic [8:0]  load_count;

   logic        wr_is_imem;
   logic        wr_is_ctrl;
   logic        wr_imem_ok;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;

   always_comb begin
      wr_is_imem = (aw_addr[11:10] == 2'b00);
      wr_is_ctrl = (aw_addr == ADDR_CTRL);
      wr_imem_ok = wr_is_imem && (w_strb == 4'hF) && !core_run;
   end

   // AW and W are captured independently; the write is committed on the edge
   // after both are held, so the imem pulse lines up with the first bvalid cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_state           <= W_IDLE;
         aw_done           <= 1'b0;
         w_done            <= 1'b0;
         aw_addr           <= '0;
         w_data            <= '0;
         w_strb            <= '0;
         bus.s_awready     <= 1'b0;
         bus.s_wready      <= 1'b0;
         bus.s_bvalid      <= 1'b0;
         bus.s_bresp       <= RESP_OKAY;
         instruction_write <= 1'b0;
         instruction_data  <= '0;
         instruction_addr  <= '0;
         core_run          <= 1'b0;
         load_count        <= '0;
      end else begin
         instruction_write <= 1'b0;
         case (w_state)
            W_IDLE: begin
               if (aw_done && w_done) begin
                  w_state      <= W_RESP;
                  bus.s_bvalid <= 1'b1;
                  if (wr_imem_ok) begin
                     instruction_write <= 1'b1;
                     instruction_addr  <= aw_addr[9:2];
                     instruction_data  <= w_data;
                     bus.s_bresp       <= RESP_OKAY;
                     if (load_count < COUNT_MAX) begin
                        load_count <= load_count + 9'd1;
                     end
                  end else if (wr_is_ctrl) begin
                     bus.s_bresp <= RESP_OKAY;
                     if (w_strb[0]) begin
                        core_run <= w_data[0];
                        if (!core_run && w_data[0]) begin
                           load_count <= '0;
                        end
                     end
                  end else begin
                     bus.s_bresp <= RESP_SLVERR;
                  end
               end else begin
                  if (bus.s_awready && bus.s_awvalid) begin
                     aw_done       <= 1'b1;
                     aw_addr       <= bus.s_awaddr;
                     bus.s_awready <= 1'b0;
                  end else if (!aw_done) begin
                     bus.s_awready <= 1'b1;
                  end
                  if (bus.s_wready && bus.s_wvalid) begin
                     w_done       <= 1'b1;
                     w_data       <= bus.s_wdata;
                     w_strb       <= bus.s_wstrb;
                     bus.s_wready <= 1'b0;
                  end else if (!w_done) begin
                     bus.s_wready <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (bus.s_bready) begin
                  w_state       <= W_IDLE;
                  bus.s_bvalid  <= 1'b0;
                  aw_done       <= 1'b0;
                  w_done        <= 1'b0;
                  bus.s_awready <= 1'b1;
                  bus.s_wready  <= 1'b1;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_SLVERR;
      if (bus.s_araddr == ADDR_CTRL) begin
         rd_data = {31'b0, core_run};
         rd_resp = RESP_OKAY;
      end else if (bus.s_araddr == ADDR_STATUS) begin
         rd_data = {core_run, 22'b0, load_count};
         rd_resp = RESP_OKAY;
      end
   end

   // Read data is captured at the AR handshake and held until the master takes it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= R_IDLE;
         bus.s_arready <= 1'b0;
         bus.s_rvalid  <= 1'b0;
         bus.s_rdata   <= '0;
         bus.s_rresp   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (bus.s_arready && bus.s_arvalid) begin
                  r_state       <= R_RESP;
                  bus.s_arready <= 1'b0;
                  bus.s_rvalid  <= 1'b1;
                  bus.s_rdata   <= rd_data;
                  bus.s_rresp   <= rd_resp;
               end else begin
                  bus.s_arready <= 1'b1;
               end
            end
            R_RESP: begin
               if (bus.s_rready) begin
                  r_state       <= R_IDLE;
                  bus.s_rvalid  <= 1'b0;
                  bus.s_arready <= 1'b1;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 The block SHALL have parameter ROW_I, default 256, meaning the instruction memory depth in 32-bit words; the addressable range is fixed at 256 words.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have ports s_awvalid in 1, s_awready out 1, s_awaddr in 12: AXI4-Lite write address, byte address.
REQ-005 The block SHALL have ports s_wvalid in 1, s_wready out 1, s_wdata in 32, s_wstrb in 4: AXI4-Lite write data.
REQ-006 The block SHALL have ports s_bvalid out 1, s_bready in 1, s_bresp out 2: AXI4-Lite write response.
REQ-007 The block SHALL have ports s_arvalid in 1, s_arready out 1, s_araddr in 12, s_rvalid out 1, s_rready in 1, s_rdata out 32, s_rresp out 2: AXI4-Lite read.
REQ-008 The block SHALL have ports instruction_write out 1, instruction_data out 32, instruction_addr out 8: the instruction memory write port.
REQ-009 The block SHALL have port core_run, output, 1; high releases the core, low holds the core so that the memory can be loaded.

Function
REQ-010 The address map SHALL be:
- 0x000-0x3FC: instruction words, word index = addr[9:2].
- 0x800: CTRL register, bit0 = run, read/write.
- 0x804: STATUS register, read-only; bits[8:0] = load_count, bit31 = core_run.
- All other addresses are unmapped.
REQ-011 The write FSM SHALL have the states W_IDLE and W_RESP.
REQ-012 In W_IDLE, s_awready and s_wready SHALL each be high until their own handshake completes; AW and W are latched independently in any order, including in the same cycle.
REQ-013 When both AW and W are latched, the block SHALL enter W_RESP on the next edge, with s_bvalid=1 and both readys low.
REQ-014 An imem write SHALL succeed only if the address is in 0x000-0x3FC, s_wstrb=4'hF and core_run=0; in that case:
- instruction_write is high for exactly one cycle, the same cycle s_bvalid first rises.
- instruction_addr = addr[9:2] and instruction_data = wdata in that cycle.
- s_bresp=OKAY.
REQ-015 An imem write that fails any condition of REQ-014 SHALL produce no instruction_write pulse and s_bresp=SLVERR (2'b10).
REQ-016 A CTRL write with s_wstrb[0]=1 SHALL update run; OKAY response.
REQ-017 Writes to STATUS or unmapped addresses SHALL have no effect and respond SLVERR.
REQ-018 W_RESP SHALL hold s_bvalid and s_bresp stable until s_bready=1, then return to W_IDLE on the next edge.
REQ-019 core_run SHALL equal the CTRL run bit, registered, changing in the cycle s_bvalid rises.
REQ-020 load_count SHALL increment by 1 per successful imem write, saturate at 256, and clear to 0 on a CTRL write that sets run from 0 to 1.
REQ-021 The read FSM SHALL have the states R_IDLE and R_RESP.
REQ-022 In R_IDLE, s_arready SHALL be high; when the AR handshake completes, the block SHALL enter R_RESP on the next edge with s_rvalid=1.
REQ-023 Read data SHALL be:
- CTRL: {31'b0, run}, OKAY.
- STATUS: per REQ-010, OKAY.
- imem range or unmapped: s_rdata=0, SLVERR.
REQ-024 R_RESP SHALL hold s_rvalid, s_rdata and s_rresp stable until s_rready=1.
REQ-025 The read and write FSMs SHALL operate concurrently, with no ordering between them.

Reset
REQ-026 While reset_n=0, asynchronously, the following SHALL be 0:
- all ready and valid outputs;
- s_bresp, s_rresp, s_rdata;
- instruction_write, instruction_data, instruction_addr;
- core_run, load_count.
REQ-027 Reset SHALL place both FSMs in their idle states.
REQ-028 An assertion of reset_n mid-transaction SHALL drop any latched AW, W or AR, and SHALL NOT produce an instruction_write pulse.
REQ-029 One cycle after reset_n deasserts, s_awready, s_wready and s_arready SHALL be 1.

Verification
REQ-030 A bench SHALL cover: AW 0x010 and W 0xDEADBEEF/strb F in the same cycle, core_run=0 -> one-cycle instruction_write, addr 0x04, data 0xDEADBEEF, bresp OKAY, load_count=1.
REQ-031 A bench SHALL cover: W first, AW 3 cycles later, with s_bready low 5 cycles -> single write pulse; bvalid held stable 5 cycles.
REQ-032 A bench SHALL cover: CTRL write 0x1, then imem write to 0x3FC -> core_run=1; no pulse; bresp SLVERR; STATUS read = 0x80000000.
REQ-033 A bench SHALL cover: 257 imem writes with run=0 -> STATUS[8:0]=256; addr 0xFF written with the last data.
REQ-034 A bench SHALL cover: strb 4'h7 imem write, and a read of 0x900 -> both SLVERR; no pulse; rdata 0.
REQ-035 A bench SHALL cover: reset_n low while AW is latched and W is pending -> all outputs 0 immediately; after release, a clean write completes normally.
